// File: rtl/regs_pkg.sv
// Shared constants for the RV32I integer register file.
package regs_pkg;

  localparam int unsigned RegNum   = 32;
  localparam int unsigned RegWidth = 32;
  localparam int unsigned RegAddrW = $clog2(RegNum);

  localparam logic [RegWidth-1:0] ZeroWord     = '0;
  localparam logic [RegAddrW-1:0] ZeroReg      = '0;
  localparam logic                WriteEnable  = 1'b1;
  localparam logic                WriteDisable = 1'b0;

endpackage

// File: rtl/regs_rport.sv
// Combinational read-port resolver: returns the post-write value of addr_i,
// honouring reset, x0, core-write bypass and debug-write bypass.
module regs_rport
  import regs_pkg::*;
#(
  parameter int unsigned AW = RegAddrW,
  parameter int unsigned DW = RegWidth
) (
  input  logic          rst_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] mem_i,
  input  logic          core_wen_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_data_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic [DW-1:0] data_o
);

  logic core_hit;
  logic dbg_hit;
  logic dbg_collide;

  always_comb begin
    core_hit    = (core_wen_i == WriteEnable) && (core_addr_i == addr_i);
    dbg_collide = (core_wen_i == WriteEnable) && (core_addr_i == dbg_addr_i);
    dbg_hit     = (dbg_we_i == WriteEnable) && (dbg_addr_i == addr_i) && !dbg_collide;

    data_o = DW'(ZeroWord);
    if (rst_i || (addr_i == AW'(ZeroReg))) begin
      data_o = DW'(ZeroWord);
    end else if (core_hit) begin
      data_o = core_data_i;
    end else if (dbg_hit) begin
      data_o = dbg_wdata_i;
    end else begin
      data_o = mem_i;
    end
  end

endmodule

// File: rtl/regs.sv
// RV32I integer register file: x0 hardwired to zero, two bypassed
// combinational read ports, and a registered debug read/write port.
module regs
  import regs_pkg::*;
#(
  parameter  int unsigned REG_NUM = RegNum,
  parameter  int unsigned DATA_W  = RegWidth,
  localparam int unsigned AW      = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_wen_i,
  input  logic [AW-1:0]     reg1_raddr_i,
  input  logic [AW-1:0]     reg2_raddr_i,
  output logic [DATA_W-1:0] reg1_rdata_o,
  output logic [DATA_W-1:0] reg2_rdata_o,
  input  logic [AW-1:0]     dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              dbg_we_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              dbg_drop_o
);

  logic [DATA_W-1:0] mem_q [REG_NUM];
  logic [DATA_W-1:0] mem_d [REG_NUM];
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              dbg_drop_q, dbg_drop_d;

  logic core_wr;
  logic dbg_collide;
  logic dbg_wr;

  always_comb begin
    core_wr     = (rd_wen_i == WriteEnable) && (rd_addr_i != AW'(ZeroReg));
    dbg_collide = (rd_wen_i == WriteEnable) && (rd_addr_i == dbg_addr_i);
    dbg_wr      = (dbg_we_i == WriteEnable) && (dbg_addr_i != AW'(ZeroReg)) && !dbg_collide;

    // Core write is applied last so it wins a same-address collision.
    mem_d = mem_q;
    if (dbg_wr) mem_d[dbg_addr_i] = dbg_wdata_i;
    if (core_wr) mem_d[rd_addr_i] = rd_data_i;

    dbg_ack_d  = dbg_we_i;
    dbg_drop_d = dbg_we_i && ((dbg_addr_i == AW'(ZeroReg)) || dbg_collide);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) mem_q[i] <= DATA_W'(ZeroWord);
      dbg_rdata_q <= DATA_W'(ZeroWord);
      dbg_ack_q   <= WriteDisable;
      dbg_drop_q  <= WriteDisable;
    end else begin
      mem_q       <= mem_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_drop_q  <= dbg_drop_d;
    end
  end

  regs_rport #(.AW(AW), .DW(DATA_W)) u_rport1 (
    .rst_i       (rst),
    .addr_i      (reg1_raddr_i),
    .mem_i       (mem_q[reg1_raddr_i]),
    .core_wen_i  (rd_wen_i),
    .core_addr_i (rd_addr_i),
    .core_data_i (rd_data_i),
    .dbg_we_i    (dbg_we_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .data_o      (reg1_rdata_o)
  );

  regs_rport #(.AW(AW), .DW(DATA_W)) u_rport2 (
    .rst_i       (rst),
    .addr_i      (reg2_raddr_i),
    .mem_i       (mem_q[reg2_raddr_i]),
    .core_wen_i  (rd_wen_i),
    .core_addr_i (rd_addr_i),
    .core_data_i (rd_data_i),
    .dbg_we_i    (dbg_we_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .data_o      (reg2_rdata_o)
  );

  regs_rport #(.AW(AW), .DW(DATA_W)) u_rport_dbg (
    .rst_i       (rst),
    .addr_i      (dbg_addr_i),
    .mem_i       (mem_q[dbg_addr_i]),
    .core_wen_i  (rd_wen_i),
    .core_addr_i (rd_addr_i),
    .core_data_i (rd_data_i),
    .dbg_we_i    (dbg_we_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .data_o      (dbg_rdata_d)
  );

  assign dbg_rdata_o = dbg_rdata_q;
  assign dbg_ack_o   = dbg_ack_q;
  assign dbg_drop_o  = dbg_drop_q;

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs: directed vector table followed by random
// traffic checked against a post-write array model of the register file.
module tb_regs;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        rd_wen_i;
  logic [4:0]  reg1_raddr_i;
  logic [4:0]  reg2_raddr_i;
  logic [31:0] reg1_rdata_o;
  logic [31:0] reg2_rdata_o;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_we_i;
  logic [31:0] dbg_rdata_o;
  logic        dbg_ack_o;
  logic        dbg_drop_o;

  regs #(.REG_NUM(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_addr_i    (rd_addr_i),
    .rd_data_i    (rd_data_i),
    .rd_wen_i     (rd_wen_i),
    .reg1_raddr_i (reg1_raddr_i),
    .reg2_raddr_i (reg2_raddr_i),
    .reg1_rdata_o (reg1_rdata_o),
    .reg2_rdata_o (reg2_rdata_o),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_wdata_i  (dbg_wdata_i),
    .dbg_we_i     (dbg_we_i),
    .dbg_rdata_o  (dbg_rdata_o),
    .dbg_ack_o    (dbg_ack_o),
    .dbg_drop_o   (dbg_drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        dwe;
    logic [4:0]  daddr;
    logic [31:0] dwdata;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [31:0] e_dbg;
    logic        e_ack;
    logic        e_drop;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic wen, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic [4:0] r1, input logic [4:0] r2,
                              input logic dwe, input logic [4:0] daddr, input logic [31:0] dwdata,
                              input logic [31:0] e_r1, input logic [31:0] e_r2,
                              input logic [31:0] e_dbg, input logic e_ack, input logic e_drop);
    vec_t v;
    v.rst = r; v.wen = wen; v.waddr = waddr; v.wdata = wdata; v.r1 = r1; v.r2 = r2;
    v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
    v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_dbg = e_dbg; v.e_ack = e_ack; v.e_drop = e_drop;
    return v;
  endfunction

  // Called just after a rising edge; drives one cycle and checks it.
  // The model: every read returns the register's value after this cycle's writes.
  task automatic run_cycle(input vec_t v, input bit use_table, input string tag);
    logic [31:0] nxt [32];
    logic [31:0] x_r1, x_r2, x_dbg;
    logic        x_ack, x_drop;
    rst = v.rst; rd_wen_i = v.wen; rd_addr_i = v.waddr; rd_data_i = v.wdata;
    reg1_raddr_i = v.r1; reg2_raddr_i = v.r2;
    dbg_we_i = v.dwe; dbg_addr_i = v.daddr; dbg_wdata_i = v.dwdata;

    nxt = model;
    if (v.rst) begin
      foreach (nxt[i]) nxt[i] = '0;
    end else begin
      if (v.dwe && v.daddr != 5'd0) nxt[v.daddr] = v.dwdata;
      if (v.wen && v.waddr != 5'd0) nxt[v.waddr] = v.wdata;
    end
    x_r1   = nxt[v.r1];
    x_r2   = nxt[v.r2];
    x_dbg  = nxt[v.daddr];
    x_ack  = !v.rst && v.dwe;
    x_drop = !v.rst && v.dwe && (v.daddr == 5'd0 || (v.wen && v.waddr == v.daddr));
    if (use_table) begin
      x_r1 = v.e_r1; x_r2 = v.e_r2; x_dbg = v.e_dbg; x_ack = v.e_ack; x_drop = v.e_drop;
    end

    #4;
    chk({tag, ".reg1"}, reg1_rdata_o, x_r1);
    chk({tag, ".reg2"}, reg2_rdata_o, x_r2);
    @(posedge clk);
    #1;
    chk({tag, ".dbg_rdata"}, dbg_rdata_o, x_dbg);
    chk({tag, ".dbg_ack"},   {31'd0, dbg_ack_o},  {31'd0, x_ack});
    chk({tag, ".dbg_drop"},  {31'd0, dbg_drop_o}, {31'd0, x_drop});
    model = nxt;
  endtask

  vec_t tbl [14];
  vec_t rv;

  initial begin
    // Directed sequence; rows run back to back from a freshly reset file.
    //            rst  wen waddr wdata          r1  r2  dwe daddr dwdata       e_r1           e_r2           e_dbg          ack  drop
    tbl[0]  = mk(1'b0, 1, 5'd0, 32'hFFFF_FFFF, 0,  0,  0, 5'd0, 32'h0,      32'h0,         32'h0,         32'h0,         0,   0);
    tbl[1]  = mk(1'b0, 0, 5'd0, 32'h0,         0,  0,  0, 5'd0, 32'h0,      32'h0,         32'h0,         32'h0,         0,   0);
    tbl[2]  = mk(1'b0, 1, 5'd7, 32'hA5A5_A5A5, 0,  7,  0, 5'd7, 32'h0,      32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5, 0,   0);
    tbl[3]  = mk(1'b0, 0, 5'd7, 32'h0,         7,  7,  0, 5'd0, 32'h0,      32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0,         0,   0);
    tbl[4]  = mk(1'b0, 1, 5'd3, 32'h11,        3,  3,  1, 5'd3, 32'h22,     32'h11,        32'h11,        32'h11,        1,   1);
    tbl[5]  = mk(1'b0, 0, 5'd0, 32'h0,         3,  0,  0, 5'd3, 32'h0,      32'h11,        32'h0,         32'h11,        0,   0);
    tbl[6]  = mk(1'b0, 1, 5'd4, 32'h44,        4,  9,  1, 5'd9, 32'h99,     32'h44,        32'h99,        32'h99,        1,   0);
    tbl[7]  = mk(1'b0, 0, 5'd0, 32'h0,         9,  4,  0, 5'd4, 32'h0,      32'h99,        32'h44,        32'h44,        0,   0);
    tbl[8]  = mk(1'b0, 0, 5'd0, 32'h0,         7,  3,  0, 5'd0, 32'h0,      32'hA5A5_A5A5, 32'h11,        32'h0,         0,   0);
    tbl[9]  = mk(1'b0, 0, 5'd0, 32'h0,         0,  4,  1, 5'd0, 32'hDEAD,   32'h0,         32'h44,        32'h0,         1,   1);
    tbl[10] = mk(1'b0, 0, 5'd0, 32'h0,         5,  9,  1, 5'd5, 32'h1234,   32'h1234,      32'h99,        32'h1234,      1,   0);
    tbl[11] = mk(1'b0, 0, 5'd0, 32'h0,         6,  5,  1, 5'd6, 32'h66,     32'h66,        32'h1234,      32'h66,        1,   0);
    tbl[12] = mk(1'b1, 1, 5'd10, 32'hAA,       5,  6,  1, 5'd8, 32'h88,     32'h0,         32'h0,         32'h0,         0,   0);
    tbl[13] = mk(1'b0, 0, 5'd0, 32'h0,         5,  8,  0, 5'd10, 32'h0,     32'h0,         32'h0,         32'h0,         0,   0);

    rst = 1'b1; rd_wen_i = 1'b0; rd_addr_i = '0; rd_data_i = '0;
    reg1_raddr_i = '0; reg2_raddr_i = '0;
    dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    foreach (model[i]) model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.dbg_rdata", dbg_rdata_o, 32'h0);
    chk("reset.dbg_ack",   {31'd0, dbg_ack_o},  32'h0);
    chk("reset.dbg_drop",  {31'd0, dbg_drop_o}, 32'h0);
    chk("reset.reg1",      reg1_rdata_o, 32'h0);

    for (int i = 0; i < 14; i++) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Reset landing on the cycle right after a debug write: no ack survives.
    rv = mk(1'b0, 0, 5'd0, 32'h0, 0, 0, 1, 5'd12, 32'hC0DE, 0, 0, 0, 0, 0);
    run_cycle(rv, 1'b0, "pre_rst_wr");
    rst = 1'b1; dbg_we_i = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_clr.dbg_ack",  {31'd0, dbg_ack_o},  32'h0);
    chk("rst_clr.dbg_drop", {31'd0, dbg_drop_o}, 32'h0);
    foreach (model[i]) model[i] = '0;
    rv = mk(1'b0, 0, 5'd0, 32'h0, 12, 0, 0, 5'd12, 32'h0, 0, 0, 0, 0, 0);
    run_cycle(rv, 1'b0, "post_rst");

    for (int n = 0; n < 400; n++) begin
      rv = mk(1'b0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 0, 0);
      rv.rst    = ($urandom_range(0, 49) == 0);
      rv.wen    = $urandom_range(0, 1) == 1;
      rv.dwe    = $urandom_range(0, 1) == 1;
      rv.waddr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rv.daddr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rv.r1     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rv.r2     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rv.wdata  = $urandom;
      rv.dwdata = $urandom;
      run_cycle(rv, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
